// File: rtl/mem_stage_lsu_pkg.sv
// rtl/mem_stage_lsu_pkg.sv - control encodings shared by the MEM stage and its align helper
package mem_stage_lsu_pkg;

    localparam logic [2:0] dm_word          = 3'b000;
    localparam logic [2:0] dm_half          = 3'b001;
    localparam logic [2:0] dm_half_unsigned = 3'b010;
    localparam logic [2:0] dm_byte          = 3'b011;
    localparam logic [2:0] dm_byte_unsigned = 3'b100;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } acc_size_e;

    // Codes 101-111 fall through to word accesses.
    function automatic acc_size_e dm_size(input logic [2:0] dmtype);
        case (dmtype)
            dm_half, dm_half_unsigned: dm_size = SZ_HALF;
            dm_byte, dm_byte_unsigned: dm_size = SZ_BYTE;
            default:                   dm_size = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane enables, store replication, load extension, misalign detect
module lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  dmtype,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] read_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = read_word[{addr_lo, 3'b000} +: 8];
    assign lane_h = addr_lo[1] ? read_word[31:16] : read_word[15:0];

    always_comb begin
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = read_word;
        misaligned = 1'b0;
        case (dm_size(dmtype))
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = (dmtype == dm_byte_unsigned) ? {24'h0, lane_b}
                                                         : {{24{lane_b[7]}}, lane_b};
            end
            SZ_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                load_data  = (dmtype == dm_half_unsigned) ? {16'h0, lane_h}
                                                          : {{16{lane_h[15]}}, lane_h};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM stage: data-memory handshake FSM and MEM/WB register
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [2:0]        ex_dmtype,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [4:0]        ex_rd,
    input  logic              ex_regwrite,
    input  logic [31:0]       ex_pc,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       wb_pc,
    output logic              misalign_exc,
    output logic [ADDR_W-1:0] misalign_addr
);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_e;

    state_e      state, state_next;
    logic [2:0]  lat_dmtype;
    logic [1:0]  lat_off;
    logic [4:0]  lat_rd;
    logic        lat_regwrite;
    logic [31:0] lat_pc;

    logic        accept, mem_op;
    logic [2:0]  al_dmtype;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_load;
    logic        al_misaligned;

    assign accept    = (state == IDLE) && ex_valid;
    assign mem_op    = ex_mem_read | ex_mem_write;
    assign mem_stall = (state == WAIT_ACK);

    // In IDLE the helper formats the incoming request; while waiting it decodes the returned word.
    assign al_dmtype = (state == IDLE) ? ex_dmtype   : lat_dmtype;
    assign al_off    = (state == IDLE) ? ex_addr[1:0] : lat_off;

    lsu_align u_align (
        .dmtype     (al_dmtype),
        .addr_lo    (al_off),
        .store_data (ex_wdata),
        .read_word  (dmem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misaligned (al_misaligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept && mem_op && !al_misaligned) state_next = WAIT_ACK;
            WAIT_ACK: if (dmem_ack) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_be       <= 4'h0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            wb_valid      <= 1'b0;
            wb_regwrite   <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= '0;
            wb_pc         <= 32'h0;
            misalign_exc  <= 1'b0;
            misalign_addr <= '0;
            lat_dmtype    <= 3'd0;
            lat_off       <= 2'd0;
            lat_rd        <= 5'd0;
            lat_regwrite  <= 1'b0;
            lat_pc        <= 32'h0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_exc <= 1'b0;
            if (accept) begin
                if (!mem_op) begin
                    wb_valid    <= 1'b1;
                    wb_regwrite <= ex_regwrite;
                    wb_rd       <= ex_rd;
                    wb_data     <= ex_addr;
                    wb_pc       <= ex_pc;
                end else if (al_misaligned) begin
                    wb_valid      <= 1'b1;
                    wb_regwrite   <= 1'b0;
                    wb_rd         <= ex_rd;
                    wb_data       <= '0;
                    wb_pc         <= ex_pc;
                    misalign_exc  <= 1'b1;
                    misalign_addr <= ex_addr;
                end else begin
                    dmem_req     <= 1'b1;
                    dmem_we      <= ex_mem_write;
                    dmem_be      <= al_be;
                    dmem_addr    <= {ex_addr[ADDR_W-1:2], 2'b00};
                    dmem_wdata   <= al_wdata;
                    lat_dmtype   <= ex_dmtype;
                    lat_off      <= ex_addr[1:0];
                    lat_rd       <= ex_rd;
                    lat_regwrite <= ex_regwrite;
                    lat_pc       <= ex_pc;
                end
            end else if (state == WAIT_ACK && dmem_ack) begin
                dmem_req    <= 1'b0;
                wb_valid    <= 1'b1;
                wb_regwrite <= dmem_we ? 1'b0 : lat_regwrite;
                wb_rd       <= lat_rd;
                wb_data     <= dmem_we ? '0 : al_load;
                wb_pc       <= lat_pc;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic [2:0]  ex_dmtype = 3'd0;
    logic [31:0] ex_addr = 32'h0, ex_wdata = 32'h0, ex_pc = 32'h0;
    logic [4:0]  ex_rd = 5'd0;
    logic        ex_regwrite = 1'b0;
    logic        mem_stall, dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_ack = 1'b0;
    logic        wb_valid, wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, wb_pc;
    logic        misalign_exc;
    logic [31:0] misalign_addr;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        regwrite;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
        logic        exc;
        logic [31:0] exc_addr;
    } wb_exp_t;

    wb_exp_t exp_q[$];

    mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_dmtype(ex_dmtype), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_pc(ex_pc),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_pc(wb_pc), .misalign_exc(misalign_exc), .misalign_addr(misalign_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every retirement pops one expectation.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (wb_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wb_valid", 32'(wb_valid), 32'd0);
                end else begin
                    wb_exp_t e;
                    e = exp_q.pop_front();
                    check("wb_regwrite", 32'(wb_regwrite), 32'(e.regwrite));
                    check("misalign_exc", 32'(misalign_exc), 32'(e.exc));
                    if (e.exc) begin
                        check("misalign_addr", misalign_addr, e.exc_addr);
                    end else begin
                        check("wb_rd", 32'(wb_rd), 32'(e.rd));
                        check("wb_data", wb_data, e.data);
                        check("wb_pc", wb_pc, e.pc);
                    end
                end
            end else if (misalign_exc === 1'b1) begin
                check("misalign_without_wb", 32'(misalign_exc), 32'd0);
            end
        end
    end

    task automatic drive(input logic rd_en, input logic wr_en, input logic [2:0] dmt,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic rw, input logic [31:0] pc);
        @(negedge clk);
        ex_mem_read  = rd_en;
        ex_mem_write = wr_en;
        ex_dmtype    = dmt;
        ex_addr      = addr;
        ex_wdata     = wdata;
        ex_rd        = rd;
        ex_regwrite  = rw;
        ex_pc        = pc;
        ex_valid     = 1'b1;
        @(posedge clk);
        #1 ex_valid = 1'b0;
    endtask

    task automatic push_exp(input logic rw, input logic [4:0] rd, input logic [31:0] data,
                            input logic [31:0] pc, input logic exc, input logic [31:0] ea);
        wb_exp_t e;
        e.regwrite = rw; e.rd = rd; e.data = data; e.pc = pc; e.exc = exc; e.exc_addr = ea;
        exp_q.push_back(e);
    endtask

    task automatic alu_op(input logic [31:0] val, input logic [4:0] rd, input logic [31:0] pc);
        push_exp(1'b1, rd, val, pc, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 3'd0, val, 32'h0, rd, 1'b1, pc);
        check("alu_dmem_req", 32'(dmem_req), 32'd0);
        check("alu_mem_stall", 32'(mem_stall), 32'd0);
    endtask

    task automatic misaligned_op(input logic wr_en, input logic [2:0] dmt, input logic [31:0] addr,
                                 input logic [31:0] pc);
        push_exp(1'b0, 5'd9, 32'h0, pc, 1'b1, addr);
        drive(~wr_en, wr_en, dmt, addr, 32'h5555_5555, 5'd9, 1'b1, pc);
        check("mis_dmem_req", 32'(dmem_req), 32'd0);
        check("mis_mem_stall", 32'(mem_stall), 32'd0);
    endtask

    task automatic mem_access(input logic wr_en, input logic [2:0] dmt, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] pc,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] rdata, input int delay,
                              input logic [31:0] exp_data, input logic inject);
        push_exp(wr_en ? 1'b0 : 1'b1, rd, exp_data, pc, 1'b0, 32'h0);
        drive(~wr_en, wr_en, dmt, addr, wdata, rd, 1'b1, pc);
        check("req", 32'(dmem_req), 32'd1);
        check("we", 32'(dmem_we), 32'(wr_en));
        check("be", 32'(dmem_be), 32'(exp_be));
        check("addr", dmem_addr, {addr[31:2], 2'b00});
        if (wr_en) check("wdata", dmem_wdata, exp_wdata);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("stall_held", 32'(mem_stall), 32'd1);
            check("req_held", 32'(dmem_req), 32'd1);
            check("be_held", 32'(dmem_be), 32'(exp_be));
            if (inject && i == 0) begin
                ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_addr = 32'hDEAD; ex_valid = 1'b1;
            end
        end
        @(negedge clk);
        ex_valid   = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        @(posedge clk);
        #1 dmem_ack = 1'b0;
        check("ack_stall_low", 32'(mem_stall), 32'd0);
        check("ack_req_low", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        #12;
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_misalign", 32'(misalign_exc), 32'd0);
        check("rst_mem_stall", 32'(mem_stall), 32'd0);
        check("rst_dmem_be", 32'(dmem_be), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        alu_op(32'h0000_1234, 5'd5, 32'h0000_1000);
        alu_op(32'hCAFE_F00D, 5'd31, 32'h0000_1004);
        // byte store, ack two cycles after req, with a blocked EX request during the wait
        mem_access(1'b1, 3'b011, 32'h103, 32'hAB, 5'd6, 32'h1008, 4'b1000, 32'hABAB_ABAB,
                   32'h0, 2, 32'h0, 1'b1);
        mem_access(1'b0, 3'b011, 32'h102, 32'h0, 5'd7, 32'h100C, 4'b0100, 32'h0,
                   32'h00F0_0000, 1, 32'hFFFF_FFF0, 1'b0);
        mem_access(1'b0, 3'b100, 32'h102, 32'h0, 5'd8, 32'h1010, 4'b0100, 32'h0,
                   32'h00F0_0000, 0, 32'h0000_00F0, 1'b0);
        mem_access(1'b0, 3'b001, 32'h202, 32'h0, 5'd10, 32'h1014, 4'b1100, 32'h0,
                   32'h8001_0000, 1, 32'hFFFF_8001, 1'b0);
        mem_access(1'b0, 3'b010, 32'h202, 32'h0, 5'd11, 32'h1018, 4'b1100, 32'h0,
                   32'h8001_0000, 0, 32'h0000_8001, 1'b0);
        misaligned_op(1'b0, 3'b000, 32'h301, 32'h101C);
        mem_access(1'b1, 3'b001, 32'h206, 32'h1234_BEEF, 5'd12, 32'h1020, 4'b1100, 32'hBEEF_BEEF,
                   32'h0, 0, 32'h0, 1'b0);
        mem_access(1'b1, 3'b000, 32'h10, 32'hDEAD_BEEF, 5'd13, 32'h1024, 4'b1111, 32'hDEAD_BEEF,
                   32'h0, 3, 32'h0, 1'b0);
        mem_access(1'b0, 3'b101, 32'h20, 32'h0, 5'd14, 32'h1028, 4'b1111, 32'h0,
                   32'h89AB_CDEF, 1, 32'h89AB_CDEF, 1'b0);
        mem_access(1'b0, 3'b011, 32'h1, 32'h0, 5'd15, 32'h102C, 4'b0010, 32'h0,
                   32'h0000_7F00, 0, 32'h0000_007F, 1'b0);
        misaligned_op(1'b1, 3'b001, 32'h105, 32'h1030);
        alu_op(32'h0000_0042, 5'd1, 32'h1034);

        // reset while a load is outstanding
        drive(1'b1, 1'b0, 3'b000, 32'h400, 32'h0, 5'd3, 1'b1, 32'h1038);
        check("rst_mid_req_before", 32'(dmem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_req", 32'(dmem_req), 32'd0);
        check("rst_mid_stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1111_1111;
        @(posedge clk);
        #1 dmem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_wb_valid", 32'(wb_valid), 32'd0);
        check("late_ack_req", 32'(dmem_req), 32'd0);

        alu_op(32'h0000_0077, 5'd2, 32'h103C);
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
